// File: rtl/nv_nvdla_attn_csb_regfile.sv
// nv_nvdla_attn_csb_regfile
//
// CSB register slave for the attention partition. Decodes CSB requests, holds a
// ping-pong (two-group) shadow bank of NUM_REG 32-bit D_CFG words, hands the
// consumer group to the attention core, and tracks per-group completion,
// interrupt status/mask and the global interrupt.
//
// Optional feature: define NVDLA_ATTN_CSB_ERR_EN to report out-of-range accesses
// and lock-dropped writes in resp_pd[32]. Undefined: the error bit is always 0.
//
// Ports:
//   nvdla_core_clk       clock
//   nvdla_core_rst       asynchronous active-high reset
//   csb2attn_req_pvld_i  CSB request valid
//   csb2attn_req_prdy_o  CSB request ready (1 whenever out of reset)
//   csb2attn_req_pd_i    request payload: addr[21:5] wdat[53:22] write[54] nposted[56:55]
//   attn2csb_resp_valid_o single-cycle response pulse
//   attn2csb_resp_pd_o   {is_write_ack, error, rdata[31:0]}
//   cfg_valid_o          op_en of the consumer group
//   cfg_data_o           D_CFG words of the consumer group, word i at [32i+31:32i]
//   cfg_group_o          consumer pointer
//   core_done_i          consumer group finished (single-cycle pulse)
//   attn2glb_intr_req_o  registered level interrupt

module nv_nvdla_attn_csb_regfile #(
  parameter int unsigned NUM_REG   = 16,
  parameter logic [16:0] BASE_ADDR = 17'h0B000
) (
  input  logic                   nvdla_core_clk,
  input  logic                   nvdla_core_rst,
  input  logic                   csb2attn_req_pvld_i,
  output logic                   csb2attn_req_prdy_o,
  input  logic [62:0]            csb2attn_req_pd_i,
  output logic                   attn2csb_resp_valid_o,
  output logic [33:0]            attn2csb_resp_pd_o,
  output logic                   cfg_valid_o,
  output logic [NUM_REG*32-1:0]  cfg_data_o,
  output logic                   cfg_group_o,
  input  logic                   core_done_i,
  output logic                   attn2glb_intr_req_o
);

  localparam logic [16:0] NumWords = 17'(NUM_REG + 5);
  localparam int unsigned CfgW     = NUM_REG * 32;

  localparam logic [16:0] OffStatus  = 17'd0;
  localparam logic [16:0] OffPointer = 17'd1;
  localparam logic [16:0] OffIntrSts = 17'd2;
  localparam logic [16:0] OffIntrMsk = 17'd3;
  localparam logic [16:0] OffOpEn    = 17'd4;
  localparam logic [16:0] OffCfg0    = 17'd5;

  // State
  logic [1:0]      op_en_q, op_en_d;
  logic [1:0]      intr_status_q, intr_status_d;
  logic [1:0]      intr_mask_q, intr_mask_d;
  logic            prod_q, prod_d;
  logic            cons_q, cons_d;
  logic [CfgW-1:0] grp_q [2];
  logic [CfgW-1:0] grp_d [2];
  logic            resp_valid_q, resp_valid_d;
  logic [33:0]     resp_pd_q, resp_pd_d;
  logic            intr_req_q, intr_req_d;

  // Request decode
  logic [16:0] req_addr;
  logic [31:0] req_wdat;
  logic        req_write;
  logic [1:0]  req_nposted;
  logic [16:0] req_off;
  logic [16:0] cfg_off;
  logic [10:0] cfg_base;
  logic        in_range;
  logic        is_d_reg;
  logic        done_eff;
  logic        releasing;
  logic        locked;
  logic        wr_en;
  logic        wr_drop;
  logic        wr_ok;
  logic        resp_err;
  logic [31:0] rdata;
  logic        unused_pd;

  assign req_addr    = csb2attn_req_pd_i[21:5];
  assign req_wdat    = csb2attn_req_pd_i[53:22];
  assign req_write   = csb2attn_req_pd_i[54];
  assign req_nposted = csb2attn_req_pd_i[56:55];
  assign unused_pd   = ^{csb2attn_req_pd_i[62:57], csb2attn_req_pd_i[4:0], cfg_off[16:6]};

  assign req_off  = req_addr - BASE_ADDR;
  assign cfg_off  = req_off - OffCfg0;
  assign cfg_base = {cfg_off[5:0], 5'b00000};
  assign in_range = (req_addr >= BASE_ADDR) && (req_off < NumWords);
  assign is_d_reg = in_range && (req_off >= OffOpEn);

  // core_done only counts while the consumer group is actually enabled.
  assign done_eff  = core_done_i & op_en_q[cons_q];
  assign releasing = done_eff & (cons_q == prod_q);

  // A D_OP_ENABLE write landing on the edge that releases the same group is a
  // rearm, not a write into a locked group, so it is let through.
  assign locked  = op_en_q[prod_q] & ~(releasing & (req_off == OffOpEn));
  assign wr_en   = csb2attn_req_pvld_i & req_write & in_range;
  assign wr_drop = wr_en & is_d_reg & locked;
  assign wr_ok   = wr_en & ~wr_drop;

`ifdef NVDLA_ATTN_CSB_ERR_EN
  assign resp_err = ~in_range | wr_drop;
`else
  assign resp_err = 1'b0;
`endif

  // Read mux always sees pre-update state.
  always_comb begin
    rdata = 32'h0;
    if (in_range) begin
      case (req_off)
        OffStatus:  rdata = {15'h0, cons_q, 14'h0, op_en_q};
        OffPointer: rdata = {15'h0, cons_q, 15'h0, prod_q};
        OffIntrSts: rdata = {30'h0, intr_status_q};
        OffIntrMsk: rdata = {30'h0, intr_mask_q};
        OffOpEn:    rdata = {31'h0, op_en_q[prod_q]};
        default:    rdata = grp_q[prod_q][cfg_base +: 32];
      endcase
    end
  end

  // Next-state logic
  always_comb begin
    op_en_d       = op_en_q;
    intr_status_d = intr_status_q;
    intr_mask_d   = intr_mask_q;
    prod_d        = prod_q;
    cons_d        = cons_q;
    grp_d[0]      = grp_q[0];
    grp_d[1]      = grp_q[1];

    if (wr_ok) begin
      case (req_off)
        OffPointer: prod_d        = req_wdat[0];
        OffIntrSts: intr_status_d = intr_status_q & ~req_wdat[1:0];
        OffIntrMsk: intr_mask_d   = req_wdat[1:0];
        default: begin
          if (req_off >= OffCfg0) begin
            grp_d[prod_q][cfg_base +: 32] = req_wdat;
          end
        end
      endcase
    end

    // Completion is applied after the W1C so a simultaneous set wins.
    if (done_eff) begin
      op_en_d[cons_q]       = 1'b0;
      intr_status_d[cons_q] = 1'b1;
      cons_d                = ~cons_q;
    end

    // Rearm applied after the completion clear so the set wins.
    if (wr_ok && (req_off == OffOpEn) && req_wdat[0]) begin
      op_en_d[prod_q] = 1'b1;
    end
  end

  // Response and interrupt
  always_comb begin
    resp_valid_d = csb2attn_req_pvld_i & (~req_write | (req_nposted != 2'b00));
    resp_pd_d    = {req_write, resp_err, (req_write ? 32'h0 : rdata)};
    intr_req_d   = |(intr_status_q & ~intr_mask_q);
  end

  always_ff @(posedge nvdla_core_clk or posedge nvdla_core_rst) begin
    if (nvdla_core_rst) begin
      op_en_q       <= 2'b00;
      intr_status_q <= 2'b00;
      intr_mask_q   <= 2'b00;
      prod_q        <= 1'b0;
      cons_q        <= 1'b0;
      grp_q[0]      <= '0;
      grp_q[1]      <= '0;
      resp_valid_q  <= 1'b0;
      resp_pd_q     <= 34'h0;
      intr_req_q    <= 1'b0;
    end else begin
      op_en_q       <= op_en_d;
      intr_status_q <= intr_status_d;
      intr_mask_q   <= intr_mask_d;
      prod_q        <= prod_d;
      cons_q        <= cons_d;
      grp_q[0]      <= grp_d[0];
      grp_q[1]      <= grp_d[1];
      resp_valid_q  <= resp_valid_d;
      resp_pd_q     <= resp_pd_d;
      intr_req_q    <= intr_req_d;
    end
  end

  assign csb2attn_req_prdy_o   = ~nvdla_core_rst;
  assign attn2csb_resp_valid_o = resp_valid_q;
  assign attn2csb_resp_pd_o    = resp_pd_q;
  assign cfg_valid_o           = op_en_q[cons_q];
  assign cfg_data_o            = grp_q[cons_q];
  assign cfg_group_o           = cons_q;
  assign attn2glb_intr_req_o   = intr_req_q;

endmodule

// File: tb/tb_nv_nvdla_attn_csb_regfile.sv
// Scoreboard bench for nv_nvdla_attn_csb_regfile: stimulus pushes expected
// responses, a negedge monitor pops and compares each response pulse.

module tb_nv_nvdla_attn_csb_regfile;

  localparam int unsigned NReg = 16;
  localparam logic [16:0] Base = 17'h0B000;
`ifdef NVDLA_ATTN_CSB_ERR_EN
  localparam logic ErrEn = 1'b1;
`else
  localparam logic ErrEn = 1'b0;
`endif

  logic               clk;
  logic               rst;
  logic               pvld;
  logic               prdy;
  logic [62:0]        pd;
  logic               resp_valid;
  logic [33:0]        resp_pd;
  logic               cfg_valid;
  logic [NReg*32-1:0] cfg_data;
  logic               cfg_group;
  logic               core_done;
  logic               intr_req;

  nv_nvdla_attn_csb_regfile #(
    .NUM_REG  (NReg),
    .BASE_ADDR(Base)
  ) dut (
    .nvdla_core_clk       (clk),
    .nvdla_core_rst       (rst),
    .csb2attn_req_pvld_i  (pvld),
    .csb2attn_req_prdy_o  (prdy),
    .csb2attn_req_pd_i    (pd),
    .attn2csb_resp_valid_o(resp_valid),
    .attn2csb_resp_pd_o   (resp_pd),
    .cfg_valid_o          (cfg_valid),
    .cfg_data_o           (cfg_data),
    .cfg_group_o          (cfg_group),
    .core_done_i          (core_done),
    .attn2glb_intr_req_o  (intr_req)
  );

  typedef struct {
    logic [33:0] pd;
    string       name;
  } exp_t;

  exp_t sb_q[$];
  int   tests = 0;
  int   fails = 0;

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [33:0] act, input logic [33:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: every response pulse must match the oldest expectation.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (resp_valid === 1'b1) begin
        tests++;
        if (sb_q.size() == 0) begin
          fails++;
          $display("FAIL unexpected_resp: got %h expected no response", resp_pd);
        end else begin
          e = sb_q.pop_front();
          if (resp_pd !== e.pd) begin
            fails++;
            $display("FAIL %s: got %h expected %h", e.name, resp_pd, e.pd);
          end
        end
      end
    end
  end

  task automatic req(input logic [16:0] addr, input logic [31:0] wdat, input logic wr,
                     input logic [1:0] np, input bit push, input logic [33:0] exp,
                     input string name);
    exp_t e;
    pd        = '0;
    pd[21:5]  = addr;
    pd[53:22] = wdat;
    pd[54]    = wr;
    pd[56:55] = np;
    pvld      = 1'b1;
    if (push) begin
      e.pd   = exp;
      e.name = name;
      sb_q.push_back(e);
    end
    @(posedge clk);
    #1;
    pvld = 1'b0;
    pd   = '0;
  endtask

  task automatic wr(input logic [16:0] off, input logic [31:0] data, input logic err,
                    input string name);
    req(Base + off, data, 1'b1, 2'b01, 1'b1, {1'b1, err, 32'h0}, name);
  endtask

  task automatic rd(input logic [16:0] off, input logic [31:0] data, input string name);
    req(Base + off, 32'h0, 1'b0, 2'b00, 1'b1, {1'b0, 1'b0, data}, name);
  endtask

  task automatic pulse_done();
    core_done = 1'b1;
    @(posedge clk);
    #1;
    core_done = 1'b0;
  endtask

  initial begin
    clk       = 1'b0;
    rst       = 1'b1;
    pvld      = 1'b0;
    pd        = '0;
    core_done = 1'b0;

    #12;
    chk("rst_resp_valid", {33'h0, resp_valid}, 34'h0);
    chk("rst_cfg_valid",  {33'h0, cfg_valid}, 34'h0);
    chk("rst_cfg_data",   {33'h0, |cfg_data}, 34'h0);
    chk("rst_cfg_group",  {33'h0, cfg_group}, 34'h0);
    chk("rst_intr",       {33'h0, intr_req}, 34'h0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    chk("prdy_high", {33'h0, prdy}, 34'h1);

    // Basic write / read
    wr(17'd5, 32'hDEADBEEF, 1'b0, "basic_wr");
    rd(17'd5, 32'hDEADBEEF, "basic_rd");

    // Ping-pong handoff
    wr(17'd5, 32'h11, 1'b0, "g0_cfg_wr");
    wr(17'd4, 32'h1, 1'b0, "g0_open");
    chk("g0_cfg_valid", {33'h0, cfg_valid}, 34'h1);
    chk("g0_cfg_data",  {2'b0, cfg_data[31:0]}, 34'h11);
    wr(17'd1, 32'h1, 1'b0, "ptr_wr1");
    rd(17'd1, 32'h1, "ptr_rd1");
    wr(17'd5, 32'h22, 1'b0, "g1_cfg_wr");
    wr(17'd4, 32'h1, 1'b0, "g1_open");
    rd(17'd0, 32'h0000_0003, "status_both");

    // Lock rule on both groups
    wr(17'd5, 32'h33, ErrEn, "lock_g1_wr");
    rd(17'd5, 32'h22, "lock_g1_rd");
    wr(17'd1, 32'h0, 1'b0, "ptr_wr0");
    wr(17'd5, 32'h44, ErrEn, "lock_g0_wr");
    rd(17'd5, 32'h11, "lock_g0_rd");
    chk("lock_cfg_data", {2'b0, cfg_data[31:0]}, 34'h11);

    // core_done hands over to group 1; interrupt one edge later
    pulse_done();
    chk("done_cfg_data",  {2'b0, cfg_data[31:0]}, 34'h22);
    chk("done_cfg_group", {33'h0, cfg_group}, 34'h1);
    chk("done_cfg_valid", {33'h0, cfg_valid}, 34'h1);
    chk("intr_not_yet",   {33'h0, intr_req}, 34'h0);
    @(posedge clk);
    #1;
    chk("intr_rise", {33'h0, intr_req}, 34'h1);
    rd(17'd0, 32'h0001_0002, "status_after_done");
    rd(17'd2, 32'h1, "intr_sts_g0");

    // Mask then W1C
    wr(17'd3, 32'h1, 1'b0, "mask_wr");
    chk("intr_mask_lag", {33'h0, intr_req}, 34'h1);
    @(posedge clk);
    #1;
    chk("intr_masked", {33'h0, intr_req}, 34'h0);
    wr(17'd2, 32'h1, 1'b0, "w1c_wr");
    rd(17'd2, 32'h0, "w1c_rd");

    // Simultaneous done and rearm on group 1
    wr(17'd1, 32'h1, 1'b0, "ptr_wr1b");
    core_done = 1'b1;
    wr(17'd4, 32'h1, 1'b0, "rearm_wr");
    core_done = 1'b0;
    rd(17'd0, 32'h0000_0002, "rearm_status");
    rd(17'd2, 32'h2, "rearm_intr_sts");
    chk("rearm_cfg_group", {33'h0, cfg_group}, 34'h0);
    chk("rearm_cfg_valid", {33'h0, cfg_valid}, 34'h0);

    // core_done with cfg_valid=0 is ignored
    pulse_done();
    rd(17'd0, 32'h0000_0002, "ign_status");
    rd(17'd2, 32'h2, "ign_intr_sts");

    // W1C and done setting the same status bit: set wins
    wr(17'd1, 32'h0, 1'b0, "ptr_wr0b");
    wr(17'd4, 32'h1, 1'b0, "g0_reopen");
    core_done = 1'b1;
    wr(17'd2, 32'h1, 1'b0, "w1c_vs_set");
    core_done = 1'b0;
    rd(17'd2, 32'h3, "w1c_vs_set_rd");
    rd(17'd0, 32'h0001_0002, "w1c_vs_set_status");

    // Posted write: no response, value lands
    req(Base + 17'd6, 32'h55, 1'b1, 2'b00, 1'b0, 34'h0, "posted");
    rd(17'd6, 32'h55, "posted_rd");
    chk("cons_g1_data", {2'b0, cfg_data[31:0]}, 34'h22);

    // Bounds
    rd(17'(4 + NReg), 32'h0, "last_word_rd");
    req(Base + 17'(5 + NReg), 32'h77, 1'b1, 2'b10, 1'b1, {1'b1, ErrEn, 32'h0}, "oor_wr");
    req(Base - 17'd1, 32'h0, 1'b0, 2'b00, 1'b1, {1'b0, ErrEn, 32'h0}, "below_base_rd");

    // Reset mid-stream: pending response lost
    chk("pre_rst_intr", {33'h0, intr_req}, 34'h1);
    req(Base, 32'h0, 1'b0, 2'b00, 1'b0, 34'h0, "lost_rd");
    rst = 1'b1;
    #1;
    chk("mid_rst_resp_valid", {33'h0, resp_valid}, 34'h0);
    chk("mid_rst_cfg_valid",  {33'h0, cfg_valid}, 34'h0);
    chk("mid_rst_cfg_data",   {33'h0, |cfg_data}, 34'h0);
    chk("mid_rst_cfg_group",  {33'h0, cfg_group}, 34'h0);
    chk("mid_rst_intr",       {33'h0, intr_req}, 34'h0);
    chk("mid_rst_prdy",       {33'h0, prdy}, 34'h0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    rd(17'd0, 32'h0, "post_rst_status");
    rd(17'd5, 32'h0, "post_rst_cfg");
    req(Base + 17'(5 + NReg), 32'h0, 1'b0, 2'b00, 1'b1, {1'b0, ErrEn, 32'h0}, "post_rst_oor_rd");

    repeat (3) @(posedge clk);
    #1;
    chk("sb_drained", 34'(sb_q.size()), 34'h0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/nv_nvdla_attn_csb_regfile.md
# nv_nvdla_attn_csb_regfile

Parametrised CSB register slave for the attention partition. It decodes CSB requests, holds a ping-pong (two-group) shadow register bank of `NUM_REG` configuration words, and hands the active group to the attention core. It also tracks per-group completion, interrupt status and mask, and drives the global interrupt. It sits between the partition's CSB ports and the attention bridge, and replaces the pass-through decode with a real register file.

## Interface

**Parameters**

- `NUM_REG`, default 16: number of 32-bit D_CFG words per group. Legal range is 1..64.
- `BASE_ADDR`, default 17'h0B000: word address of offset 0.

**Ports**

- `nvdla_core_clk` in 1: the single clock.
- `nvdla_core_rst` in 1: reset, asynchronous and active-high.
- `csb2attn_req_pvld` in 1: CSB request valid.
- `csb2attn_req_prdy` out 1: CSB request ready.
- `csb2attn_req_pd` in 63: request payload.
  - addr[21:5], wdat[53:22], write[54], nposted[56:55].
- `attn2csb_resp_valid` out 1: single-cycle response pulse.
- `attn2csb_resp_pd` out 34: response payload.
  - [33] is_write_ack, [32] error, [31:0] rdata.
- `cfg_valid` out 1: op_en of the consumer group.
- `cfg_data` out NUM_REG*32: D_CFG words of the consumer group; word i is at [32i+31:32i].
- `cfg_group` out 1: consumer pointer.
- `core_done` in 1: single-cycle pulse; the consumer group's operation has finished.
- `attn2glb_intr_req` out 1: interrupt, level, registered.

## Operation

**Request acceptance**

- `csb2attn_req_prdy` is 1 whenever out of reset.
- A request is accepted on any cycle with pvld=1.
- Decode uses offset = addr − BASE_ADDR. The address is in range iff addr ≥ BASE_ADDR and offset < 5+NUM_REG.

**Register map (word offsets)**

- 0 S_STATUS (RO): [1:0] op_en per group; [16] consumer pointer.
- 1 S_POINTER (RW): [0] producer pointer, RW; [16] consumer pointer, RO.
- 2 S_INTR_STATUS (W1C): [1:0] done per group.
- 3 S_INTR_MASK (RW): [1:0]. A 1 masks that group.
- 4 D_OP_ENABLE: writing bit0=1 sets op_en[producer]; writing 0 has no effect. Reads return op_en[producer].
- 5..4+NUM_REG D_CFG[i]: read and written in the producer group.

**Lock rule**

- A write to any D_ register whose producer group has op_en=1 is dropped.

**Responses**

- Read: resp_valid with [33]=0 and rdata.
- Write with nposted≠0: resp_valid with [33]=1 and rdata=0.
- Posted write: no response.
- An out-of-range read returns rdata=0. An out-of-range write is dropped.

**Core handshake**

- When `core_done` is sampled:
  - op_en[consumer] is cleared.
  - intr_status[consumer] is set.
  - The consumer pointer toggles.
- `core_done` while cfg_valid=0 is ignored entirely.

**Interrupt**

- `attn2glb_intr_req` is the registered value of |(intr_status & ~intr_mask).

**Simultaneous events** (request and core_done on the same edge)

- If D_OP_ENABLE is set for the same group that core_done clears, the set wins and op_en stays 1.
- If a W1C clears the same intr_status bit that core_done sets, the set wins.
- Reads sampled on that edge return pre-update values.

## Timing

- Reset value of every output is 0; this includes cfg_data and cfg_group. All registers, pointers, the mask and the status reset to 0.
- Response latency:
  - Request accepted at edge N gives resp_valid high for exactly the cycle after edge N.
  - Back-to-back requests give back-to-back responses.
  - There is no response backpressure.
- A register write at edge N is visible on cfg_data, or in a read sampled at edge N+1, from the cycle after edge N.
- Interrupt latency: core_done sampled at edge N sets intr_status at N; attn2glb_intr_req rises at edge N+1.
- cfg_valid and cfg_data switch groups on the edge that samples core_done.
- If reset asserts mid-operation, everything clears immediately (asynchronous). A pending response is lost; no pulse is emitted after reset.

## Configuration

- `NVDLA_ATTN_CSB_ERR_EN` defined: resp_pd[32]=1 for out-of-range accesses and for writes dropped by the lock rule.
- Not defined: resp_pd[32] is always 0. Drop behaviour is unchanged.

## Test plan

- **Basic write/read:** with ERR_EN, nonposted write 0xDEADBEEF to offset 5, then read offset 5.
  - Required: write response pd=34'h2_0000_0000; read response pd=34'h0_DEAD_BEEF.
- **Ping-pong handoff:** write D_CFG[0]=0x11 in group 0 and set D_OP_ENABLE, then write pointer=1, write D_CFG[0]=0x22, set D_OP_ENABLE.
  - Required: cfg_valid=1 and cfg_data[31:0]=0x11.
  - Pulse core_done: cfg_data[31:0]=0x22, cfg_group=1, S_STATUS reads 0x0001_0002.
- **Lock rule:** with op_en[0]=1 and producer=0, nonposted write to D_CFG[0].
  - Required: value unchanged, resp_pd[32]=1 with ERR_EN and 0 without it.
- **Interrupt and mask:** with mask=0, core_done on group 0.
  - Required: intr_req rises one edge after done.
  - Write mask=1: intr_req falls. W1C status=1: status reads 0.
- **Simultaneous done and rearm:** core_done and a D_OP_ENABLE write to the same group on the same edge.
  - Required: op_en stays 1, intr_status bit set, consumer pointer toggled.
- **Reset and bounds:** assert reset mid-stream; all outputs 0 immediately. Then read address BASE_ADDR+5+NUM_REG.
  - Required: rdata=0, error=1 with ERR_EN.
